// File: rtl/chargen_uart_gen.sv
// Chargen source: pattern generator -> sync FIFO -> UART TX, plus status LEDs; start bit leaves one cycle after pop.
// The generator stalls on FIFO full or pause and never drops a byte. Define UART_PARITY_EN for 8E1/8E2 framing.
module chargen_uart_gen #(
    parameter int FIFO_DEPTH     = 16,
    parameter int UART_CDIV      = 434,
    parameter int BLINK_INTERVAL = 25000000,
    parameter int LINE_LEN       = 72,
    parameter int STOP_BITS      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] dip,
    output logic [2:0] led,
    input  logic       uart_rx,
    output logic       uart_tx
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int IDXW = $clog2(LINE_LEN + 2);
    localparam int DW   = $clog2(UART_CDIV);
    localparam int HBW  = (BLINK_INTERVAL > 1) ? $clog2(BLINK_INTERVAL) : 1;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} tx_state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;
`endif

    function automatic logic [6:0] inc95(input logic [6:0] v);
        return (v == 7'd94) ? 7'd0 : v + 7'd1;
    endfunction

    logic w_unused_rx;
    assign w_unused_rx = uart_rx;

    // generator state
    logic [IDXW-1:0] r_idx;
    logic [6:0]      r_off;
    logic [6:0]      r_c0;
    logic [6:0]      r_c1;
    logic [1:0]      r_mode;
    logic [1:0]      w_mode;
    logic            w_push;
    logic [7:0]      w_byte;
    logic [6:0]      w_off_nxt;

    // fifo state
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [AW:0]     r_cnt;
    logic [AW:0]     w_cnt_nxt;
    logic            r_full;
    logic            r_empty;
    logic [7:0]      w_rd_dat;

    // tx state
    tx_state_t       r_state;
    tx_state_t       w_state_nxt;
    logic [DW-1:0]   r_div;
    logic [DW-1:0]   w_div_nxt;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_nxt;
    logic [7:0]      r_sh;
    logic [7:0]      w_sh_nxt;
    logic            r_par;
    logic            w_par_nxt;
    logic            w_pop;
    logic            w_bit_end;
    logic            w_tx_nxt;
    logic            r_tx;
    logic            r_busy;

    logic [HBW-1:0]  r_hb_cnt;
    logic            r_hb;

    // Mode is live from the DIPs at line start so an idle line can restart without a push.
    assign w_mode    = (r_idx == '0) ? dip[1:0] : r_mode;
    assign w_push    = !r_full && !dip[2] && (w_mode != 2'd3);
    assign w_off_nxt = inc95(r_off);

    always_comb begin
        w_byte = 8'h55;
        if (r_idx == IDXW'(LINE_LEN)) begin
            w_byte = 8'h0D;
        end else if (r_idx == IDXW'(LINE_LEN + 1)) begin
            w_byte = 8'h0A;
        end else begin
            case (w_mode)
                2'd0:    w_byte = 8'h20 + {1'b0, r_c0};
                2'd1:    w_byte = 8'h20 + {1'b0, r_c1};
                default: w_byte = 8'h55;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_off  <= '0;
            r_c0   <= '0;
            r_c1   <= '0;
            r_mode <= '0;
        end else if (w_push) begin
            if (r_idx == '0) begin
                r_mode <= dip[1:0];
            end
            if (r_idx == IDXW'(LINE_LEN + 1)) begin
                r_idx <= '0;
                r_off <= w_off_nxt;
                r_c0  <= w_off_nxt;
            end else begin
                r_idx <= r_idx + IDXW'(1);
                if (r_idx < IDXW'(LINE_LEN)) begin
                    if (w_mode == 2'd0) r_c0 <= inc95(r_c0);
                    if (w_mode == 2'd1) r_c1 <= inc95(r_c1);
                end
            end
        end
    end

    assign w_cnt_nxt = r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    assign w_rd_dat  = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= w_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == (AW+1)'(FIFO_DEPTH));
            r_empty <= (w_cnt_nxt == '0);
        end
    end

    assign w_bit_end = (r_div == DW'(UART_CDIV - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = w_bit_end ? '0 : r_div + DW'(1);
        w_bit_nxt   = r_bit;
        w_sh_nxt    = r_sh;
        w_par_nxt   = r_par;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_div_nxt = '0;
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_sh_nxt    = w_rd_dat;
                    w_par_nxt   = ^w_rd_dat;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_sh_nxt = {1'b0, r_sh[7:1]};
                    if (r_bit == 3'd7) begin
                        w_bit_nxt   = '0;
`ifdef UART_PARITY_EN
                        w_state_nxt = S_PAR;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PAR: begin
                if (w_bit_end) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit == 3'(STOP_BITS - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Line level is registered from the next state so uart_tx is glitch-free.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_sh_nxt[0];
`ifdef UART_PARITY_EN
            S_PAR:   w_tx_nxt = w_par_nxt;
`endif
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_sh    <= w_sh_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hb_cnt <= '0;
            r_hb     <= 1'b0;
        end else if (r_hb_cnt == HBW'(BLINK_INTERVAL - 1)) begin
            r_hb_cnt <= '0;
            r_hb     <= ~r_hb;
        end else begin
            r_hb_cnt <= r_hb_cnt + HBW'(1);
        end
    end

    assign led     = {r_busy, r_full, r_hb};
    assign uart_tx = r_tx;

endmodule

// File: tb/tb_chargen_uart_gen.sv
// Bench for chargen_uart_gen: UART frames are decoded from the line and popped against an expected-byte queue.
module tb_chargen_uart_gen;

    localparam int CDIV = 4;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int SPACING = (10 + PB) * CDIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst2 = 1'b1;
    logic [2:0] dip = 3'd3;
    logic [2:0] dip2 = 3'd0;
    logic [2:0] led;
    logic [2:0] led2;
    logic       tx;
    logic       tx2;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    chargen_uart_gen #(.FIFO_DEPTH(4), .UART_CDIV(CDIV), .BLINK_INTERVAL(4), .LINE_LEN(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .dip(dip), .led(led), .uart_rx(1'b1), .uart_tx(tx));

    chargen_uart_gen #(.FIFO_DEPTH(4), .UART_CDIV(CDIV), .BLINK_INTERVAL(4), .LINE_LEN(96), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst2), .dip(dip2), .led(led2), .uart_rx(1'b1), .uart_tx(tx2));

    // n-th byte of a mode-0 stream from reset with line length l
    function automatic logic [7:0] m0_byte(input int n, input int l);
        int line;
        int i;
        line = n / (l + 2);
        i    = n % (l + 2);
        if (i == l)     return 8'h0D;
        if (i == l + 1) return 8'h0A;
        return 8'(8'h20 + ((line + i) % 95));
    endfunction

    // Called on a negedge; returns mid-stop-bit. ok=0 when no start bit within bound cycles.
    task automatic rx_frame(input bit sel, input int bound, output logic [7:0] b, output logic sb,
                            output logic pb, output logic stp, output logic busy, output int t0, output bit ok);
        int n;
        n = 0; ok = 0; b = '0; sb = 1'b1; pb = 1'b0; stp = 1'b0; busy = 1'b0; t0 = 0;
        while ((sel ? tx2 : tx) !== 1'b0) begin
            if (n >= bound) return;
            @(negedge clk);
            n++;
        end
        ok = 1; t0 = cyc;
        repeat (CDIV / 2) @(negedge clk);
        sb = sel ? tx2 : tx;
        for (int i = 0; i < 8; i++) begin
            repeat (CDIV) @(negedge clk);
            b[i] = sel ? tx2 : tx;
        end
        if (PB == 1) begin
            repeat (CDIV) @(negedge clk);
            pb = sel ? tx2 : tx;
        end
        repeat (CDIV) @(negedge clk);
        stp  = sel ? tx2 : tx;
        busy = sel ? led2[2] : led[2];
    endtask

    task automatic do_reset(input logic [2:0] d);
        @(negedge clk);
        rst = 1'b1; dip = d;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic [7:0] b; logic sb, pb, stp, busy; int t0; bit ok;
        repeat (2) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
        total++; if (led !== 3'b000) begin bad++; $display("FAIL reset_led got=%b want=000", led); end
        rst = 1'b0; dip = 3'd0;
        n = 0;
        while (tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        repeat (6) @(negedge clk);
        total++; if (led[2] !== 1'b1) begin bad++; $display("FAIL busy_midframe got=%b want=1", led[2]); end
        rst = 1'b1; dip = 3'd3;
        @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL midframe_rst_tx got=%b want=1", tx); end
        total++; if (led !== 3'b000) begin bad++; $display("FAIL midframe_rst_led got=%b want=000", led); end
        @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_hold_tx got=%b want=1", tx); end
        rst = 1'b0;
        rx_frame(0, 200, b, sb, pb, stp, busy, t0, ok);
        total++; if (ok !== 1'b0) begin bad++; $display("FAIL no_frame_after_reset got=%b want=0", ok); end
    endtask

    task automatic test_mode0();
        logic [7:0] b, e; logic sb, pb, stp, busy; int t0, tp; bit ok;
        dip = 3'd0;
        for (int n = 0; n < 20; n++) exp_q.push_back(m0_byte(n, 4));
        tp = 0;
        for (int k = 0; k < 20; k++) begin
            rx_frame(0, 400, b, sb, pb, stp, busy, t0, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL mode0_timeout frame=%0d", k); break; end
            e = exp_q.pop_front();
            if (b !== e) begin bad++; $display("FAIL mode0_byte[%0d] got=%h want=%h", k, b, e); end
            total++; if (sb !== 1'b0 || stp !== 1'b1) begin bad++; $display("FAIL mode0_framing[%0d] start=%b stop=%b want 0/1", k, sb, stp); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL mode0_led2[%0d] got=%b want=1", k, busy); end
            if (k > 0) begin
                total++;
                if (t0 - tp != SPACING) begin bad++; $display("FAIL mode0_spacing[%0d] got=%0d want=%0d", k, t0 - tp, SPACING); end
            end
            tp = t0;
        end
        exp_q.delete();
    endtask

    task automatic test_mode1();
        logic [7:0] b, e; logic sb, pb, stp, busy; int t0; bit ok; int c;
        do_reset(3'd1);
        c = 0;
        for (int n = 0; n < 12; n++) begin
            if (n % 6 == 4)      exp_q.push_back(8'h0D);
            else if (n % 6 == 5) exp_q.push_back(8'h0A);
            else begin exp_q.push_back(8'(8'h20 + (c % 95))); c++; end
        end
        for (int k = 0; k < 12; k++) begin
            rx_frame(0, 400, b, sb, pb, stp, busy, t0, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL mode1_timeout frame=%0d", k); break; end
            e = exp_q.pop_front();
            if (b !== e) begin bad++; $display("FAIL mode1_byte[%0d] got=%h want=%h", k, b, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_line_wrap();
        logic [7:0] b, e; logic sb, pb, stp, busy; int t0; bit ok;
        @(negedge clk);
        rst2 = 1'b0;
        for (int n = 0; n < 100; n++) exp_q.push_back(m0_byte(n, 96));
        for (int k = 0; k < 100; k++) begin
            rx_frame(1, 400, b, sb, pb, stp, busy, t0, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL wrap_timeout frame=%0d", k); break; end
            e = exp_q.pop_front();
            if (b !== e) begin bad++; $display("FAIL wrap_byte[%0d] got=%h want=%h", k, b, e); end
        end
        exp_q.delete();
        rst2 = 1'b1;
    endtask

    task automatic test_mode2_to_3();
        logic [7:0] b, e; logic sb, pb, stp, busy; int t0, tp; bit ok;
        do_reset(3'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        dip = 3'd3;
        for (int n = 0; n < 4; n++) exp_q.push_back(8'h55);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        tp = 0;
        for (int k = 0; k < 6; k++) begin
            rx_frame(0, 400, b, sb, pb, stp, busy, t0, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL mode2_timeout frame=%0d", k); break; end
            e = exp_q.pop_front();
            if (b !== e) begin bad++; $display("FAIL mode2_byte[%0d] got=%h want=%h", k, b, e); end
            if (k > 0) begin
                total++;
                if (t0 - tp != SPACING) begin bad++; $display("FAIL mode2_spacing[%0d] got=%0d want=%0d", k, t0 - tp, SPACING); end
            end
            tp = t0;
        end
        rx_frame(0, 300, b, sb, pb, stp, busy, t0, ok);
        total++; if (ok !== 1'b0) begin bad++; $display("FAIL mode3_idle frame_seen=%b want=0 byte=%h", ok, b); end
        exp_q.delete();
    endtask

    task automatic test_pause();
        logic [7:0] b, e; logic sb, pb, stp, busy; int t0; bit ok; int drained;
        do_reset(3'd0);
        for (int n = 0; n < 13; n++) exp_q.push_back(m0_byte(n, 4));
        rx_frame(0, 400, b, sb, pb, stp, busy, t0, ok);
        e = exp_q.pop_front();
        total++; if (!ok || b !== e) begin bad++; $display("FAIL pause_first got=%h ok=%b want=%h", b, ok, e); end
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL pause_full got=%b want=1", led[1]); end
        dip = 3'b100;
        drained = 0;
        for (int k = 0; k < 8; k++) begin
            rx_frame(0, 200, b, sb, pb, stp, busy, t0, ok);
            if (!ok) break;
            drained++;
            e = exp_q.pop_front();
            total++; if (b !== e) begin bad++; $display("FAIL pause_drain[%0d] got=%h want=%h", k, b, e); end
        end
        total++; if (drained != 4) begin bad++; $display("FAIL pause_drain_count got=%0d want=4", drained); end
        total++; if (led[1] !== 1'b0) begin bad++; $display("FAIL pause_not_full got=%b want=0", led[1]); end
        dip = 3'b000;
        for (int k = 0; k < 12 && exp_q.size() > 0; k++) begin
            rx_frame(0, 400, b, sb, pb, stp, busy, t0, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL resume_timeout frame=%0d", k); break; end
            e = exp_q.pop_front();
            if (b !== e) begin bad++; $display("FAIL resume_byte[%0d] got=%h want=%h", k, b, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_heartbeat_parity();
        logic [7:0] b, e; logic sb, pb, stp, busy; int t0, tp; bit ok;
        do_reset(3'd3);
        for (int k = 0; k < 16; k++) begin
            total++;
            if (led[0] !== 1'((k / 4) % 2)) begin bad++; $display("FAIL heartbeat[%0d] got=%b want=%0d", k, led[0], (k / 4) % 2); end
            @(negedge clk);
        end
        dip = 3'd0;
        exp_q.push_back(8'h20); exp_q.push_back(8'h21); exp_q.push_back(8'h22);
        tp = 0;
        for (int k = 0; k < 3; k++) begin
            rx_frame(0, 400, b, sb, pb, stp, busy, t0, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL parity_timeout frame=%0d", k); break; end
            e = exp_q.pop_front();
            if (b !== e) begin bad++; $display("FAIL parity_byte[%0d] got=%h want=%h", k, b, e); end
`ifdef UART_PARITY_EN
            total++; if (pb !== ^e) begin bad++; $display("FAIL parity_bit[%0d] got=%b want=%b", k, pb, ^e); end
`endif
            if (k > 0) begin
                total++;
                if (t0 - tp != SPACING) begin bad++; $display("FAIL parity_spacing[%0d] got=%0d want=%0d", k, t0 - tp, SPACING); end
            end
            tp = t0;
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_line_wrap();
        test_mode2_to_3();
        test_pause();
        test_heartbeat_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
